// File: rtl/connect4_turn_controller_if.sv
// Move request / board status bundle between the game front end and the
// Connect-4 turn controller.
//   master : drives move_valid, move_col, new_game; observes board and status
//   slave  : the controller; observes requests, drives board and status
interface connect4_turn_controller_if #(
    parameter int COLS  = 4,
    parameter int ROWS  = 4,
    parameter int COL_W = 4
);
    localparam int CELLS  = COLS * ROWS;
    localparam int CELL_W = $clog2(CELLS);

    logic                move_valid;
    logic [COL_W-1:0]    move_col;
    logic                new_game;
    logic [CELLS-1:0]    occupied;
    logic [CELLS-1:0]    colour;
    logic                cur_player;
    logic                busy;
    logic                move_ack;
    logic                move_reject;
    logic [CELL_W-1:0]   last_cell;
    logic                game_over;
    logic [1:0]          winner;

    modport master (
        output move_valid, move_col, new_game,
        input  occupied, colour, cur_player, busy, move_ack, move_reject,
               last_cell, game_over, winner
    );

    modport slave (
        input  move_valid, move_col, new_game,
        output occupied, colour, cur_player, busy, move_ack, move_reject,
               last_cell, game_over, winner
    );
endinterface

// File: rtl/connect4_turn_controller.sv
// Connect-4 game sequencer. Validates a move, drops the disc into the lowest
// free cell of the column, scans the four line directions through the new
// disc (one per cycle), then either ends the game or passes the turn.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : slave side of connect4_turn_controller_if (move request in,
//            occupancy/colour bitmaps, turn and result status out)
//
// state | meaning
// IDLE  | waiting for a move from cur_player
// WIN0  | scan vertical run through last_cell
// WIN1  | scan horizontal run
// WIN2  | scan diagonal (+col,+row) run
// WIN3  | scan anti-diagonal (+col,-row) run, then decide outcome
// OVER  | game finished, board frozen until new_game / reset
module connect4_turn_controller #(
    parameter int COLS    = 4,
    parameter int ROWS    = 4,
    parameter int WIN_LEN = 4,
    parameter int COL_W   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    connect4_turn_controller_if.slave  bus
);
    localparam int CELLS  = COLS * ROWS;
    localparam int CELL_W = $clog2(CELLS);
    localparam int CIDX_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int HGT_W  = $clog2(ROWS + 1);
    localparam int MC_W   = $clog2(CELLS + 1);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] WIN0 = 3'd1;
    localparam logic [2:0] WIN1 = 3'd2;
    localparam logic [2:0] WIN2 = 3'd3;
    localparam logic [2:0] WIN3 = 3'd4;
    localparam logic [2:0] OVER = 3'd5;

    logic [2:0]         state;
    logic [CELLS-1:0]   occupied_q;
    logic [CELLS-1:0]   colour_q;
    logic               cur_player_q;
    logic               move_ack_q;
    logic               move_reject_q;
    logic [CELL_W-1:0]  last_cell_q;
    logic [1:0]         winner_q;
    logic               win_flag;
    logic [MC_W-1:0]    move_count;
    logic [HGT_W-1:0]   height [COLS];

    logic [CIDX_W-1:0]  col_idx;
    logic               col_in_range;
    logic               col_full;
    logic [CELL_W-1:0]  new_cell;

    assign col_idx      = bus.move_col[CIDX_W-1:0];
    assign col_in_range = int'(bus.move_col) < COLS;
    assign col_full     = col_in_range && (height[col_idx] == HGT_W'(ROWS));
    assign new_cell     = CELL_W'(int'(height[col_idx]) * COLS + int'(col_idx));

    // A neighbour only extends the run if it is on the board (no wrap between
    // rows) and holds a disc of the player who just moved.
    function automatic logic same_colour(input int r, input int c,
                                         input logic [CELLS-1:0] occ,
                                         input logic [CELLS-1:0] col,
                                         input logic who);
        logic              hit;
        logic [CELL_W-1:0] idx;
        hit = 1'b0;
        idx = '0;
        if (r >= 0 && r < ROWS && c >= 0 && c < COLS) begin
            idx = CELL_W'(r * COLS + c);
            hit = occ[idx] && (col[idx] == who);
        end
        return hit;
    endfunction

    int   lc_row, lc_col, dr, dc, run;
    logic fwd_open, bwd_open, dir_win;

    always_comb begin
        lc_row   = int'(last_cell_q) / COLS;
        lc_col   = int'(last_cell_q) % COLS;
        dr       = 0;
        dc       = 0;
        case (state)
            WIN0:    dr = 1;
            WIN1:    dc = 1;
            WIN2:    begin dc = 1; dr = 1;  end
            WIN3:    begin dc = 1; dr = -1; end
            default: ;
        endcase
        run      = 1;
        fwd_open = 1'b1;
        bwd_open = 1'b1;
        for (int k = 1; k < WIN_LEN; k++) begin
            if (fwd_open && same_colour(lc_row + k*dr, lc_col + k*dc,
                                        occupied_q, colour_q, cur_player_q))
                run = run + 1;
            else
                fwd_open = 1'b0;
            if (bwd_open && same_colour(lc_row - k*dr, lc_col - k*dc,
                                        occupied_q, colour_q, cur_player_q))
                run = run + 1;
            else
                bwd_open = 1'b0;
        end
        dir_win = (run >= WIN_LEN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            occupied_q    <= '0;
            colour_q      <= '0;
            cur_player_q  <= 1'b0;
            move_ack_q    <= 1'b0;
            move_reject_q <= 1'b0;
            last_cell_q   <= '0;
            winner_q      <= 2'b00;
            win_flag      <= 1'b0;
            move_count    <= '0;
            for (int i = 0; i < COLS; i++) height[i] <= '0;
        end else if (bus.new_game) begin
            state         <= IDLE;
            occupied_q    <= '0;
            colour_q      <= '0;
            cur_player_q  <= 1'b0;
            move_ack_q    <= 1'b0;
            move_reject_q <= 1'b0;
            last_cell_q   <= '0;
            winner_q      <= 2'b00;
            win_flag      <= 1'b0;
            move_count    <= '0;
            for (int i = 0; i < COLS; i++) height[i] <= '0;
        end else begin
            move_ack_q    <= 1'b0;
            move_reject_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.move_valid) begin
                        if (!col_in_range || col_full) begin
                            move_reject_q <= 1'b1;
                        end else begin
                            occupied_q[new_cell] <= 1'b1;
                            colour_q[new_cell]   <= cur_player_q;
                            height[col_idx]      <= height[col_idx] + 1'b1;
                            move_count           <= move_count + 1'b1;
                            last_cell_q          <= new_cell;
                            win_flag             <= 1'b0;
                            move_ack_q           <= 1'b1;
                            state                <= WIN0;
                        end
                    end
                end
                WIN0, WIN1, WIN2: begin
                    if (dir_win) win_flag <= 1'b1;
                    state <= state + 3'd1;
                end
                WIN3: begin
                    if (win_flag || dir_win) begin
                        winner_q <= cur_player_q ? 2'b10 : 2'b01;
                        state    <= OVER;
                    end else if (move_count == MC_W'(CELLS)) begin
                        winner_q <= 2'b11;
                        state    <= OVER;
                    end else begin
                        cur_player_q <= ~cur_player_q;
                        state        <= IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.occupied    = occupied_q;
    assign bus.colour      = colour_q;
    assign bus.cur_player  = cur_player_q;
    assign bus.busy        = (state == WIN0) || (state == WIN1) ||
                             (state == WIN2) || (state == WIN3);
    assign bus.move_ack    = move_ack_q;
    assign bus.move_reject = move_reject_q;
    assign bus.last_cell   = last_cell_q;
    assign bus.game_over   = (state == OVER);
    assign bus.winner      = winner_q;
endmodule

// File: tb/tb_connect4_turn_controller.sv
module tb_connect4_turn_controller;
    localparam int COLS = 4, ROWS = 4, WIN_LEN = 4, COL_W = 4;
    localparam int CELLS = COLS * ROWS;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    connect4_turn_controller_if #(.COLS(COLS), .ROWS(ROWS), .COL_W(COL_W)) bus();

    connect4_turn_controller #(.COLS(COLS), .ROWS(ROWS), .WIN_LEN(WIN_LEN), .COL_W(COL_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: board[r][c] = 0 empty, 1 P1, 2 P2.
    int board [ROWS][COLS];
    int m_height [COLS];
    int m_player, m_winner, m_last, m_count;
    bit m_over;

    typedef struct {
        bit         ng;
        int         col;
        bit         ack;
        bit         rej;
        logic [1:0] win;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) board[r][c] = 0;
        for (int c = 0; c < COLS; c++) m_height[c] = 0;
        m_player = 0; m_winner = 0; m_last = 0; m_count = 0; m_over = 0;
    endtask

    // Any WIN_LEN-long straight line anywhere on the board owned by p.
    function automatic bit model_win(input int p);
        int drs[4] = '{1, 0, 1, -1};
        int dcs[4] = '{0, 1, 1, 1};
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                for (int d = 0; d < 4; d++) begin
                    bit all = 1;
                    for (int k = 0; k < WIN_LEN; k++) begin
                        int rr = r + k * drs[d];
                        int cc = c + k * dcs[d];
                        if (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS) all = 0;
                        else if (board[rr][cc] != p) all = 0;
                    end
                    if (all) return 1;
                end
        return 0;
    endfunction

    task automatic check_state(input string tag);
        logic [CELLS-1:0] eo, ec;
        eo = '0; ec = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                eo[r*COLS+c] = (board[r][c] != 0);
                ec[r*COLS+c] = (board[r][c] == 2);
            end
        check({tag, ".occupied"},   32'(bus.occupied),   32'(eo));
        check({tag, ".colour"},     32'(bus.colour),     32'(ec));
        check({tag, ".cur_player"}, 32'(bus.cur_player), 32'(m_player));
        check({tag, ".winner"},     32'(bus.winner),     32'(m_winner));
        check({tag, ".game_over"},  32'(bus.game_over),  32'(m_over));
        check({tag, ".busy"},       32'(bus.busy),       32'd0);
        check({tag, ".last_cell"},  32'(bus.last_cell),  32'(m_last));
    endtask

    task automatic pulse_new_game();
        @(negedge clk); bus.new_game = 1'b1;
        @(negedge clk); bus.new_game = 1'b0;
        model_reset();
        check_state("new_game");
        check("new_game.acks", 32'({bus.move_ack, bus.move_reject}), 32'd0);
    endtask

    task automatic do_move(input int col, output bit got_ack, output bit got_rej);
        logic [31:0] colv;
        colv = 32'(col);
        @(negedge clk);
        bus.move_valid = 1'b1;
        bus.move_col   = colv[COL_W-1:0];
        @(negedge clk);
        bus.move_valid = 1'b0;
        got_ack = bus.move_ack;
        got_rej = bus.move_reject;
        if (m_over) begin
            check("ignored.ack", 32'(got_ack), 32'd0);
            check("ignored.rej", 32'(got_rej), 32'd0);
            check_state("ignored");
        end else if (col >= COLS || m_height[col] == ROWS) begin
            check("reject.ack", 32'(got_ack), 32'd0);
            check("reject.rej", 32'(got_rej), 32'd1);
            check_state("reject");
        end else begin
            board[m_height[col]][col] = m_player + 1;
            m_last = m_height[col] * COLS + col;
            m_height[col]++;
            m_count++;
            check("accept.ack",  32'(got_ack),       32'd1);
            check("accept.rej",  32'(got_rej),       32'd0);
            check("accept.busy", 32'(bus.busy),      32'd1);
            check("accept.cell", 32'(bus.last_cell), 32'(m_last));
            repeat (3) begin
                @(negedge clk);
                check("eval.busy",  32'(bus.busy), 32'd1);
                check("eval.pulse", 32'({bus.move_ack, bus.move_reject}), 32'd0);
            end
            @(negedge clk);
            if (model_win(m_player + 1)) begin
                m_over = 1; m_winner = m_player + 1;
            end else if (m_count == CELLS) begin
                m_over = 1; m_winner = 3;
            end else begin
                m_player ^= 1;
            end
            check_state("after_move");
        end
    endtask

    function automatic void add(input bit ng, input int col, input bit ack, input bit rej,
                                input logic [1:0] win);
        vec_t v;
        v.ng = ng; v.col = col; v.ack = ack; v.rej = rej; v.win = win;
        tbl.push_back(v);
    endfunction

    initial begin
        bit a, r;
        int s2[6]  = '{1, 1, 1, 1, 1, 7};
        int s3[8]  = '{0, 0, 1, 1, 2, 2, 3, 3};
        int s4[12] = '{1, 0, 2, 1, 3, 2, 3, 2, 0, 3, 0, 3};
        int sw[7]  = '{1, 0, 2, 2, 3, 1, 0};
        int s5[16] = '{0, 1, 0, 1, 1, 0, 1, 0, 2, 3, 2, 3, 3, 2, 3, 2};

        bus.move_valid = 1'b0;
        bus.move_col   = '0;
        bus.new_game   = 1'b0;
        model_reset();

        // Column full and out-of-range column
        foreach (s2[i]) add(i == 0, s2[i], i < 4, i >= 4, 2'b00);
        // Row-0 win for P1, then a move after game over is ignored
        foreach (s3[i]) add(i == 0, s3[i], i < 7, 1'b0, (i >= 6) ? 2'b01 : 2'b00);
        // Diagonal win for P2 at cells 0,5,10,15
        foreach (s4[i]) add(i == 0, s4[i], 1'b1, 1'b0, (i == 11) ? 2'b10 : 2'b00);
        // P1 on cells 1,2,3,4: contiguous in index but wraps a row edge
        foreach (sw[i]) add(i == 0, sw[i], 1'b1, 1'b0, 2'b00);
        // Full board without any four-run
        foreach (s5[i]) add(i == 0, s5[i], 1'b1, 1'b0, (i == 15) ? 2'b11 : 2'b00);

        repeat (2) @(negedge clk);
        check_state("reset");
        check("reset.acks", 32'({bus.move_ack, bus.move_reject}), 32'd0);
        rst_n = 1'b1;

        // First move after reset into column 2
        do_move(2, a, r);
        check("first.occ2", 32'(bus.occupied[2]), 32'd1);
        check("first.col2", 32'(bus.colour[2]),   32'd0);
        check("first.turn", 32'(bus.cur_player),  32'd1);

        foreach (tbl[i]) begin
            if (tbl[i].ng) pulse_new_game();
            do_move(tbl[i].col, a, r);
            check($sformatf("tbl[%0d].ack", i), 32'(a), 32'(tbl[i].ack));
            check($sformatf("tbl[%0d].rej", i), 32'(r), 32'(tbl[i].rej));
            check($sformatf("tbl[%0d].winner", i), 32'(bus.winner), 32'(tbl[i].win));
        end

        // new_game while in WIN2 aborts the move in flight
        pulse_new_game();
        @(negedge clk); bus.move_valid = 1'b1; bus.move_col = 4'd0;
        @(negedge clk); bus.move_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); bus.new_game = 1'b1;
        @(negedge clk); bus.new_game = 1'b0;
        model_reset();
        check_state("abort");
        repeat (4) begin
            @(negedge clk);
            check("abort.no_ack", 32'({bus.move_ack, bus.busy}), 32'd0);
        end
        do_move(1, a, r);
        check("abort.next_ack", 32'(a), 32'd1);

        // new_game and move_valid in the same cycle: clear wins
        @(negedge clk); bus.move_valid = 1'b1; bus.move_col = 4'd2; bus.new_game = 1'b1;
        @(negedge clk); bus.move_valid = 1'b0; bus.new_game = 1'b0;
        model_reset();
        check_state("ng_vs_move");
        check("ng_vs_move.acks", 32'({bus.move_ack, bus.move_reject}), 32'd0);

        // Asynchronous reset mid-evaluation
        do_move(0, a, r);
        do_move(1, a, r);
        @(negedge clk); bus.move_valid = 1'b1; bus.move_col = 4'd2;
        @(posedge clk); #2; bus.move_valid = 1'b0; rst_n = 1'b0;
        #1;
        model_reset();
        check_state("async_rst");
        check("async_rst.acks", 32'({bus.move_ack, bus.move_reject}), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        do_move(3, a, r);
        check("post_rst.ack", 32'(a), 32'd1);

        // Random games against the model
        for (int g = 0; g < 8; g++) begin
            pulse_new_game();
            for (int m = 0; m < 24 && !m_over; m++) begin
                int c;
                c = ($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, COLS));
                do_move(c, a, r);
            end
            do_move(int'($urandom_range(0, COLS - 1)), a, r);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
